// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving one shared valid/ready channel from N requesters.
// A requester owns the channel from the cycle after it wins until its transfer or withdrawal.
module rr_mux_arbiter #(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] data_in,
   output logic [N-1:0]   grant,
   output logic [SW-1:0]  sel,
   output logic           valid_out,
   output logic [W-1:0]   data_out,
   input  logic           ready_out,
   output logic           busy
);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_sel;
   logic [SW-1:0] r_last;
   logic [SW-1:0] w_winner;
   logic [SW:0]   w_idx;
   logic          w_found;
   logic          w_any;
   logic          w_sel_req;
   logic [W-1:0]  w_sel_data;
   logic          w_valid;
   logic          w_xfer;

   assign w_any = |req;

   // Rotating search starting just after the last requester that completed a transfer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_winner = r_last;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = {1'b0, r_last} + (SW+1)'(k);
         if (w_idx >= (SW+1)'(N)) w_idx = w_idx - (SW+1)'(N);
         if (!w_found && req[w_idx[SW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[SW-1:0];
         end
      end
   end

   // Only the owner's lane is ever looked at, so other requesters cannot disturb the output.
   always_comb begin
      w_sel_req  = 1'b0;
      w_sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (r_sel == SW'(i)) begin
            w_sel_req  = req[i];
            w_sel_data = data_in[i*W +: W];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_OWN;
         S_OWN:   if (!w_sel_req || ready_out) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_valid   = (r_state == S_OWN) && w_sel_req;
   assign w_xfer    = w_valid && ready_out;
   assign valid_out = w_valid;
   assign data_out  = w_valid ? w_sel_data : '0;
   assign grant     = w_xfer ? (N'(1) << r_sel) : '0;
   assign sel       = r_sel;
   assign busy      = (r_state == S_OWN);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_last  <= SW'(N-1);
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any) r_sel <= w_winner;
         // A withdrawal leaves r_last alone so the requester keeps its place in the rotation.
         if (w_xfer) r_last <= r_sel;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus a random phase
// checked every cycle against a behavioural owner/last-winner model.
module tb_rr_mux_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   grant;
   logic [1:0]     sel;
   logic           valid_out;
   logic [W-1:0]   data_out;
   logic           ready_out;
   logic           busy;

   int errors = 0;
   int checks = 0;

   rr_mux_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in), .grant(grant), .sel(sel),
      .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: who owns the channel (-1 = nobody), who last completed, and the select value.
   int m_owner;
   int m_last;
   int m_sel;
   int m_wait [N];

   function automatic int pick_winner(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1;
         m_last  = N - 1;
         m_sel   = 0;
         for (int i = 0; i < N; i++) m_wait[i] = 0;
      end else begin
         for (int i = 0; i < N; i++) if (!req[i]) m_wait[i] = 0;
         if (m_owner < 0) begin
            if (req != '0) begin
               m_owner = pick_winner(req, m_last);
               m_sel   = m_owner;
               for (int i = 0; i < N; i++) begin
                  if (i != m_owner && req[i]) begin
                     m_wait[i]++;
                     check("fairness_wait_lt_N", 32'(m_wait[i] < N), 32'd1);
                  end
               end
            end
         end else if (req[m_owner]) begin
            if (ready_out) begin
               m_wait[m_owner] = 0;
               m_last  = m_owner;
               m_owner = -1;
            end
         end else begin
            m_owner = -1;
         end
      end
   end

   // Compare process: outputs are stable mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      logic         e_valid;
      logic [W-1:0] e_data;
      logic [N-1:0] e_grant;
      e_valid = (m_owner >= 0) ? req[m_owner] : 1'b0;
      e_data  = e_valid ? data_in[m_owner*W +: W] : '0;
      e_grant = (e_valid && ready_out) ? (N'(1) << m_owner) : '0;
      check("m_valid", valid_out, e_valid);
      check("m_data",  data_out,  e_data);
      check("m_grant", grant,     e_grant);
      check("m_busy",  busy,      m_owner >= 0);
      check("m_sel",   sel,       m_sel);
      check("m_onehot0", $onehot0(grant), 1'b1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   logic [N-1:0] exp_g [5];
   logic [W-1:0] exp_d [5];
   logic [N-1:0] g;

   initial begin
      rst = 1'b1; req = '0; data_in = '0; ready_out = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      check("rst_valid", valid_out, 1'b0);
      check("rst_busy",  busy,      1'b0);
      check("rst_grant", grant,     4'b0000);
      check("rst_sel",   sel,       2'd0);
      check("rst_data",  data_out,  8'h00);

      // Single requester, immediate transfer.
      req = 4'b0001; data_in[7:0] = 8'hA5; ready_out = 1'b1;
      #1 check("t1_idle_valid", valid_out, 1'b0);
      cyc(); #1;
      check("t1_sel",   sel,       2'd0);
      check("t1_valid", valid_out, 1'b1);
      check("t1_data",  data_out,  8'hA5);
      check("t1_grant", grant,     4'b0001);
      cyc();
      req = 4'b0000; #1;
      check("t1_after_valid", valid_out, 1'b0);
      check("t1_after_busy",  busy,      1'b0);

      // All requesting: strict rotation starting at 0.
      do_reset();
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      exp_d[0] = 8'h00;   exp_d[1] = 8'h11;   exp_d[2] = 8'h22;   exp_d[3] = 8'h33;   exp_d[4] = 8'h00;
      req = 4'b1111; ready_out = 1'b1;
      for (int i = 0; i < N; i++) data_in[i*W +: W] = 8'(i * 8'h11);
      for (int k = 0; k < 5; k++) begin
         #1 check("t2_idle_grant", grant, 4'b0000);
         cyc(); #1;
         check("t2_grant", grant,    exp_g[k]);
         check("t2_data",  data_out, exp_d[k]);
         cyc();
      end

      // Establish last=1, then stall requester 2 for three cycles.
      req = 4'b0010;
      cyc(); #1 check("t3_pre_grant", grant, 4'b0010);
      cyc();
      req = 4'b0110; ready_out = 1'b0;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_stall_sel",   sel,       2'd2);
         check("t3_stall_valid", valid_out, 1'b1);
         check("t3_stall_data",  data_out,  8'h22);
         check("t3_stall_grant", grant,     4'b0000);
         cyc();
      end
      ready_out = 1'b1; #1;
      check("t3_grant", grant,    4'b0100);
      check("t3_data",  data_out, 8'h22);
      cyc();

      // Withdrawal by requester 3 keeps its rotation slot (last stays 2).
      req = 4'b1000; ready_out = 1'b0;
      cyc(); #1;
      check("t4_sel",   sel,      2'd3);
      check("t4_data",  data_out, 8'h33);
      req = 4'b0010; #1;
      check("t4_wd_valid", valid_out, 1'b0);
      check("t4_wd_data",  data_out,  8'h00);
      check("t4_wd_grant", grant,     4'b0000);
      cyc();
      req = 4'b1010; #1;
      check("t4_idle_busy", busy, 1'b0);
      cyc(); #1;
      check("t4_rewin_sel", sel, 2'd3);

      // Asynchronous reset during a stalled ownership of requester 2.
      ready_out = 1'b1;
      cyc();
      req = 4'b0100; ready_out = 1'b0;
      cyc(); #1;
      check("t5_stall_sel", sel, 2'd2);
      rst = 1'b1; #1;
      check("t5_rst_valid", valid_out, 1'b0);
      check("t5_rst_busy",  busy,      1'b0);
      check("t5_rst_grant", grant,     4'b0000);
      check("t5_rst_data",  data_out,  8'h00);
      check("t5_rst_sel",   sel,       2'd0);
      cyc();
      rst = 1'b0;
      req = 4'b0101; ready_out = 1'b1;
      cyc(); #1;
      check("t5_sel",   sel,   2'd0);
      check("t5_grant", grant, 4'b0001);
      cyc();
      req = 4'b0000;

      // Random phase: requesters hold req and data until granted.
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               data_in[i*W +: W] = 8'($urandom);
            end
         end
         ready_out = ($urandom_range(0, 3) != 0);
         #3 g = grant;
         cyc();
         for (int i = 0; i < N; i++) if (g[i]) req[i] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
